io_input_port: RTL

Input-direction peripheral on the I/O bus: buffers bytes pushed by the emulator host (keyboard, serial stand-in) in a small FIFO and returns them to the CPU when the CPU reads from the device. It is the device-to-CPU counterpart of the display/LCD output devices. It sits behind the I/O controller and shares `io_bus`, the active-low row/column selects and `from_devn` with those devices.

---
 rtl/io_pkg.sv | 35 +++
 rtl/io_input_port_if.sv | 22 ++
 rtl/io_fifo_sync.sv | 54 +++++
 rtl/io_input_port.sv | 90 +++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the I/O bus input device: status layout, empty-read value, FIFO depth limits.
// Optional IRQ output of io_input_port is enabled with IO_INPUT_IRQ_EN.
package io_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEPTH_MIN   = 2;
  localparam int unsigned DEPTH_MAX   = 16;
  localparam int unsigned DEPTH_DEF   = 16;

  // Status register bit positions
  localparam int unsigned ST_AVAIL    = 0;
  localparam int unsigned ST_FULL     = 1;
  localparam int unsigned ST_CNT_LSB  = 2;
  localparam int unsigned ST_OVR      = 7;
  localparam int unsigned CNT_FIELD_W = ST_OVR - ST_CNT_LSB;

  localparam logic [DATA_W-1:0] EMPTY_READ = 8'h00;

  // Assemble the status byte from its fields
  function automatic logic [DATA_W-1:0] pack_status(
    input logic                   ovr,
    input logic [CNT_FIELD_W-1:0] cnt,
    input logic                   full,
    input logic                   avail
  );
    logic [DATA_W-1:0] s;
    s                             = '0;
    s[ST_OVR]                     = ovr;
    s[ST_CNT_LSB +: CNT_FIELD_W]  = cnt;
    s[ST_FULL]                    = full;
    s[ST_AVAIL]                   = avail;
    return s;
  endfunction

endpackage

// File: rtl/io_input_port_if.sv
// Host push handshake plus CPU read decode lines of the input device.
interface io_input_port_if;
  import io_pkg::*;

  logic [DATA_W-1:0] host_data;
  logic              host_valid;
  logic              host_ready;
  logic              sel_data_n;
  logic              sel_status_n;
  logic              from_devn;

  modport master (
    output host_data, host_valid, sel_data_n, sel_status_n, from_devn,
    input  host_ready
  );

  modport slave (
    input  host_data, host_valid, sel_data_n, sel_status_n, from_devn,
    output host_ready
  );

endinterface

// File: rtl/io_fifo_sync.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
module io_fifo_sync
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     out_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop_ok)  rd_ptr <= AW'(rd_ptr + 1'b1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_input_port.sv
// I/O bus input device: host bytes are queued and returned to the CPU on data reads.
// Define IO_INPUT_IRQ_EN to add the active-low data-available output irq_n.
module io_input_port
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               out_rst,
  io_input_port_if.slave     dev,
  inout  wire [DATA_W-1:0]   io_bus
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic               irq_n
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              rd_data;
  logic              rd_stat;
  logic              stat_act;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              ovr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] bus_val;

  // Data select has priority when both selects are asserted
  assign rd_data  = !dev.sel_data_n && !dev.from_devn;
  assign rd_stat  = !dev.sel_status_n && !dev.from_devn;
  assign stat_act = rd_stat && !rd_data;

  assign dev.host_ready = !full;
  assign push           = dev.host_valid && !full;
  assign pop            = rd_data && !empty;

  io_fifo_sync #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .out_rst (out_rst),
    .push    (push),
    .pop     (pop),
    .wdata   (dev.host_data),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky overrun; a drop on the same edge as a status read keeps it set
  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) begin
      ovr <= 1'b0;
    end else if (dev.host_valid && full) begin
      ovr <= 1'b1;
    end else if (stat_act) begin
      ovr <= 1'b0;
    end
  end

  always_comb begin
    bus_val = EMPTY_READ;
    if (out_rst) begin
      bus_val = EMPTY_READ;
    end else if (rd_data) begin
      bus_val = empty ? EMPTY_READ : head;
    end else if (stat_act) begin
      bus_val = pack_status(ovr, CNT_FIELD_W'(count), full, !empty);
    end
  end

  assign io_bus = (rd_data || stat_act) ? bus_val : {DATA_W{1'bz}};

`ifdef IO_INPUT_IRQ_EN
  // Follows the registered count, so it lags a count change by one edge
  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) begin
      irq_n <= 1'b1;
    end else begin
      irq_n <= (count == '0);
    end
  end
`endif

endmodule
